// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter with lock, bounded tenure, BUSY hold and a dead turnaround cycle.
// Optional split-transaction masking is enabled by defining ARB_SPLIT_EN.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MAX_TENURE  = 16,
  parameter int unsigned OWNER_W     = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] BREQ,
  input  logic [NUM_MASTERS-1:0] BLOCK,
  input  logic                   BUSY,
  output logic [NUM_MASTERS-1:0] BGRANT,
  output logic [OWNER_W-1:0]     BOWNER,
  output logic                   BVALID
`ifdef ARB_SPLIT_EN
  ,
  input  logic                   SPLIT,
  input  logic [NUM_MASTERS-1:0] SPLIT_DONE,
  output logic [NUM_MASTERS-1:0] SPLIT_MASK
`endif
);

  localparam int unsigned CNT_W = (MAX_TENURE == 0) ? 1 : $clog2(MAX_TENURE + 1);
  localparam logic [CNT_W-1:0] TEN_MAX = CNT_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0] TEN_THR = CNT_W'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HANDOVER
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;

  logic [NUM_MASTERS-1:0] split_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] own_mask;
  logic                   others_eligible;
  logic                   tenure_rel;
  logic                   split_hit;
  logic                   win_found;
  logic [OWNER_W-1:0]     win_idx;
  logic [OWNER_W-1:0]     cand;

  assign eligible        = BREQ & ~split_mask;
  assign own_mask        = NUM_MASTERS'(1) << owner_q;
  assign others_eligible = |(eligible & ~own_mask);
  assign tenure_rel      = (MAX_TENURE != 0) && (count_q >= TEN_THR) &&
                           !BLOCK[owner_q] && others_eligible;

`ifdef ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] split_q, split_d;

  assign split_hit  = (state_q == S_GRANT) && SPLIT;
  assign split_mask = split_q;
  assign SPLIT_MASK = split_q;

  // Set beats clear when both hit the same master on one edge
  always_comb begin
    split_d = (split_q & ~SPLIT_DONE) | (split_hit ? own_mask : '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) split_q <= '0;
    else       split_q <= split_d;
  end
`else
  assign split_hit  = 1'b0;
  assign split_mask = '0;
`endif

  // First eligible master searching upward from ptr+1, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = OWNER_W'((32'(ptr_q) + k) % NUM_MASTERS);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= OWNER_W'(NUM_MASTERS - 1);
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_HANDOVER: begin
        grant_d = '0;
        if (win_found) begin
          state_d = S_GRANT;
          grant_d = NUM_MASTERS'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx;
          count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (count_q < TEN_MAX) count_d = count_q + CNT_W'(1);
        // Split forces release even with a transfer in flight
        if (split_hit || (!BUSY && (!BREQ[owner_q] || tenure_rel))) begin
          state_d = S_HANDOVER;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    valid_d = |grant_d;
  end

  assign BGRANT = grant_q;
  assign BOWNER = owner_q;
  assign BVALID = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed table-driven bench for bus_arbiter_rr (2 masters, tenure 4).
// Define ARB_SPLIT_EN to also exercise the split-mask sequence.
module tb_bus_arbiter_rr;

  logic       clk;
  logic       rstn;
  logic [1:0] breq;
  logic [1:0] block;
  logic       busy;
  logic [1:0] bgrant;
  logic       bowner;
  logic       bvalid;
`ifdef ARB_SPLIT_EN
  logic       split;
  logic [1:0] split_done;
  logic [1:0] split_mask;
`endif

  int n_vec;
  int n_err;

  bus_arbiter_rr #(
    .NUM_MASTERS(2),
    .MAX_TENURE (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .BREQ      (breq),
    .BLOCK     (block),
    .BUSY      (busy),
    .BGRANT    (bgrant),
    .BOWNER    (bowner),
    .BVALID    (bvalid)
`ifdef ARB_SPLIT_EN
    ,
    .SPLIT     (split),
    .SPLIT_DONE(split_done),
    .SPLIT_MASK(split_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] breq;
    logic [1:0] block;
    logic       busy;
    logic [1:0] g;
    logic       o;
    logic       v;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] rq, input logic [1:0] lk, input logic bz,
                              input logic [1:0] g, input logic o, input logic v);
    vec_t t;
    t.breq = rq; t.block = lk; t.busy = bz; t.g = g; t.o = o; t.v = v;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] lk, input logic bz);
    breq  = rq;
    block = lk;
    busy  = bz;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {4'b0, bgrant, bowner, bvalid};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    breq  = '0;
    block = '0;
    busy  = 1'b0;
`ifdef ARB_SPLIT_EN
    split      = 1'b0;
    split_done = '0;
`endif

    // Owner alone: tenure never forces release
    for (int i = 0; i < 6; i++) add(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
    add(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    // Both requesting: 4 grant cycles, 1 dead cycle, alternate
    for (int i = 0; i < 4; i++) add(2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    add(2'b11, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
    add(2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    // Owner drops as the other master raises
    add(2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    add(2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    add(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
    // Lock holds past tenure, release as soon as lock drops
    for (int i = 0; i < 10; i++) add(2'b11, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1);
    add(2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    // Owner drops request while BUSY: hold until BUSY falls
    for (int i = 0; i < 3; i++) add(2'b01, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1);
    add(2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    add(2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
    // BUSY also blocks tenure rotation
    for (int i = 0; i < 6; i++) add(2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1);
    add(2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    add(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    #12;
    check("reset_state", outs(), 8'b0000_0000);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].breq, vecs[i].block, vecs[i].busy);
      check($sformatf("vec%0d", i), outs(), {4'b0, vecs[i].g, vecs[i].o, vecs[i].v});
    end

    // Async reset mid-grant, then master 0 wins first again
    step(2'b10, 2'b00, 1'b0);
    check("pre_reset_grant", outs(), {4'b0, 2'b10, 1'b1, 1'b1});
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_drop", outs(), 8'b0000_0000);
    breq = 2'b11;
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_first", outs(), {4'b0, 2'b01, 1'b0, 1'b1});
    step(2'b00, 2'b00, 1'b0);
    check("post_reset_handover", outs(), {4'b0, 2'b00, 1'b0, 1'b0});
    step(2'b00, 2'b00, 1'b0);
    check("post_reset_idle", outs(), {4'b0, 2'b00, 1'b0, 1'b0});

`ifdef ARB_SPLIT_EN
    // Split masks master 0 until SPLIT_DONE
    step(2'b01, 2'b00, 1'b0);
    check("split_owner0", outs(), {4'b0, 2'b01, 1'b0, 1'b1});
    split = 1'b1;
    step(2'b11, 2'b00, 1'b1);
    split = 1'b0;
    check("split_release", outs(), {4'b0, 2'b00, 1'b0, 1'b0});
    check("split_mask_set", {6'b0, split_mask}, 8'b0000_0001);
    step(2'b11, 2'b00, 1'b0);
    check("split_grant1", outs(), {4'b0, 2'b10, 1'b1, 1'b1});
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 2'b00, 1'b0);
      check($sformatf("split_hold%0d", i), outs(), {4'b0, 2'b10, 1'b1, 1'b1});
    end
    split_done = 2'b01;
    step(2'b11, 2'b00, 1'b0);
    split_done = 2'b00;
    check("split_done_grant", outs(), {4'b0, 2'b10, 1'b1, 1'b1});
    check("split_mask_clr", {6'b0, split_mask}, 8'b0000_0000);
    step(2'b11, 2'b00, 1'b0);
    check("split_rot_dead", outs(), {4'b0, 2'b00, 1'b1, 1'b0});
    step(2'b11, 2'b00, 1'b0);
    check("split_rot_grant0", outs(), {4'b0, 2'b01, 1'b0, 1'b1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
